// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types for the iterative multiply/divide unit.
//   muldiv_op_t   - 3-bit operation code driven into the unit by CPU control
//   FUNC_*        - R-type funct field values that select a HI/LO operation
//   func_is_md    - true when a funct value belongs to this unit
//   func_to_mdop  - funct -> muldiv_op_t (qualify with func_is_md first)
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  function automatic logic func_is_md(input logic [5:0] f);
    return f inside {FUNC_MTHI, FUNC_MTLO, FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
  endfunction

  function automatic muldiv_op_t func_to_mdop(input logic [5:0] f);
    muldiv_op_t op;
    case (f)
      FUNC_MULTU: op = MD_MULTU;
      FUNC_DIV:   op = MD_DIV;
      FUNC_DIVU:  op = MD_DIVU;
      FUNC_MTHI:  op = MD_MTHI;
      FUNC_MTLO:  op = MD_MTLO;
      default:    op = MD_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/status bundle between CPU control and muldiv_unit.
//   master (CPU side): drives start_i, op_i, rs_i, rt_i, flush_i;
//                      reads busy_o, done_o, hi_o, lo_o
//   slave  (unit side): the mirror image
import muldiv_unit_pkg::*;

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  muldiv_op_t       op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide owning the HI/LO register pair.
// One shift datapath, one bit per cycle, WIDTH+1 cycles start-to-commit.
// Ports:
//   clk      - clock
//   reset_i  - synchronous active-high reset (IDLE, HI=LO=0)
//   md       - muldiv_unit_if.slave: start/op/rs/rt/flush in,
//              busy/done/hi/lo out
import muldiv_unit_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         reset_i,
  muldiv_unit_if.slave md
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} md_state_t;

  // Accumulator is {upper WIDTH+1 bits, lower WIDTH bits}:
  //   multiply: {P, multiplier}  divide: {R, Q}
  localparam int AW = 2 * WIDTH + 1;

  md_state_t        r_state, w_state_nxt;
  logic [AW-1:0]    r_acc;
  logic [WIDTH:0]   r_opb;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_done;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_busy;
  logic             w_accept;
  logic             w_arith;
  logic             w_div_op;
  logic             w_signed;
  logic             w_sa, w_sb;
  logic [WIDTH:0]   w_ext_a, w_ext_b;
  logic [WIDTH:0]   w_abs_a, w_abs_b;
  logic             w_last;
  logic             w_commit;

  logic [WIDTH:0]   w_sum;
  logic [AW-1:0]    w_mul_nxt;
  logic [AW-1:0]    w_sh;
  logic [WIDTH+1:0] w_diff;
  logic [AW-1:0]    w_div_nxt;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;

  assign w_busy   = (r_state != S_IDLE);
  // Flush in IDLE swallows a start presented in the same cycle.
  assign w_accept = (r_state == S_IDLE) && md.start_i && !md.flush_i;
  assign w_arith  = md.op_i inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  assign w_div_op = md.op_i inside {MD_DIV, MD_DIVU};
  assign w_signed = md.op_i inside {MD_MULT, MD_DIV};
  assign w_sa     = w_signed & md.rs_i[WIDTH-1];
  assign w_sb     = w_signed & md.rt_i[WIDTH-1];

  // Magnitudes in WIDTH+1 bits so |-2^(WIDTH-1)| is representable.
  assign w_ext_a  = {w_sa, md.rs_i};
  assign w_ext_b  = {w_sb, md.rt_i};
  assign w_abs_a  = w_sa ? (~w_ext_a + 1'b1) : w_ext_a;
  assign w_abs_b  = w_sb ? (~w_ext_b + 1'b1) : w_ext_b;

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // Flush wins over the commit in the FIX cycle.
  assign w_commit = (r_state == S_FIX) && !md.flush_i;

  // Multiply step: conditional add into P, then shift {P, mplier} right.
  assign w_sum     = r_acc[AW-1:WIDTH] + (r_acc[0] ? r_opb : '0);
  assign w_mul_nxt = {1'b0, w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift left, trial subtract, keep if non-negative.
  assign w_sh      = {r_acc[AW-2:0], 1'b0};
  assign w_diff    = {1'b0, w_sh[AW-1:WIDTH]} - {1'b0, r_opb};
  assign w_div_nxt = w_diff[WIDTH+1] ? w_sh
                                     : {w_diff[WIDTH:0], w_sh[WIDTH-1:1], 1'b1};

  // Sign fix-up and result selection for the commit.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
    w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      // Divide by zero runs full latency but commits zeros.
      w_hi_res = r_dz ? '0 : w_rem;
      w_lo_res = r_dz ? '0 : w_quo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_arith) w_state_nxt = S_CALC;
      S_CALC: begin
        if (md.flush_i)  w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        case (md.op_i)
          MD_MTHI: r_hi <= md.rs_i;
          MD_MTLO: r_lo <= md.rs_i;
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            r_is_div <= w_div_op;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_dz     <= (md.rt_i == '0);
            r_cnt    <= '0;
            if (w_div_op) begin
              r_acc <= {{(WIDTH+1){1'b0}}, w_abs_a[WIDTH-1:0]};
              r_opb <= w_abs_b;
            end else begin
              r_acc <= {{(WIDTH+1){1'b0}}, w_abs_b[WIDTH-1:0]};
              r_opb <= w_abs_a;
            end
          end
          default: ;
        endcase
      end
      if (r_state == S_CALC) begin
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end

  assign md.busy_o = w_busy;
  assign md.done_o = r_done;
  assign md.hi_o   = r_hi;
  assign md.lo_o   = r_lo;

  // A start while busy is dropped; flag it so the controller bug is visible.
  a_start_busy: assert property (@(posedge clk) disable iff (reset_i)
                                 !(md.start_i && w_busy))
    else $warning("muldiv_unit: start_i ignored while busy");

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit (WIDTH=32).
// Driver pushes the reference-model result per operation; a negedge monitor
// pops and compares whenever done_o is seen.
import muldiv_unit_pkg::*;

module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) md();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_i(reset_i), .md(md));

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;  // architectural HI/LO model

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions: {HI, LO}.
  function automatic logic [63:0] model(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (op)
      MD_MULT:  p = sa * sb;
      MD_MULTU: p = ua * ub;
      MD_DIV: if (b != 0) begin
        q = sa / sb;  r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      MD_DIVU: if (b != 0) begin
        q = longint'(ua / ub);  r = longint'(ua % ub);
        p = {r[31:0], q[31:0]};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  always @(negedge clk) begin
    if (md.done_o) begin
      logic [63:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op");
      end else begin
        e = exp_q.pop_front();
        chk("sb_hi", {32'b0, md.hi_o}, {32'b0, e[63:32]});
        chk("sb_lo", {32'b0, md.lo_o}, {32'b0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
    end
  end

  // Issue one arithmetic op. flush_at/rst_at/intr_at are cycle indices after
  // acceptance (-1 = unused). Returns #1 after the done edge when not aborted.
  task automatic run_op(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int flush_at, input int rst_at, input int intr_at);
    int n, busyc, d0;
    bit abort;
    abort = (flush_at >= 0) || (rst_at >= 0);
    if (!abort) exp_q.push_back(model(op, a, b));
    md.op_i = op; md.rs_i = a; md.rt_i = b; md.start_i = 1'b1;
    @(posedge clk); #1;
    md.start_i = 1'b0;
    n = 0; busyc = 0;
    while (!md.done_o && n < 100) begin
      if (md.busy_o) busyc++;
      md.start_i = (n == intr_at);
      if (n == intr_at) begin
        md.op_i = MD_DIVU; md.rs_i = $urandom; md.rt_i = $urandom;
      end
      md.flush_i = (n == flush_at);
      reset_i    = (n == rst_at);
      @(posedge clk); #1;
      n++;
      md.start_i = 1'b0; md.flush_i = 1'b0; reset_i = 1'b0;
      if ((flush_at >= 0 && n == flush_at + 1) || (rst_at >= 0 && n == rst_at + 1)) break;
    end
    if (abort) begin
      if (rst_at >= 0) begin m_hi = '0; m_lo = '0; end
      chk("abort_busy", {63'b0, md.busy_o}, 64'd0);
      chk("abort_hi", {32'b0, md.hi_o}, {32'b0, m_hi});
      chk("abort_lo", {32'b0, md.lo_o}, {32'b0, m_lo});
      d0 = done_cnt;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      chk("abort_hold_hi", {32'b0, md.hi_o}, {32'b0, m_hi});
    end else begin
      chk("latency", 64'(n), 64'(W + 1));
      chk("busy_cycles", 64'(busyc), 64'(W + 1));
    end
  endtask

  task automatic mt(input muldiv_op_t op, input logic [W-1:0] v);
    md.op_i = op; md.rs_i = v; md.start_i = 1'b1;
    @(posedge clk); #1;
    md.start_i = 1'b0;
    if (op == MD_MTHI) m_hi = v; else m_lo = v;
    chk("mt_hi", {32'b0, md.hi_o}, {32'b0, m_hi});
    chk("mt_lo", {32'b0, md.lo_o}, {32'b0, m_lo});
    chk("mt_no_done", {63'b0, md.done_o}, 64'd0);
    chk("mt_no_busy", {63'b0, md.busy_o}, 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_i = 1'b1;
    md.start_i = 1'b0; md.flush_i = 1'b0; md.op_i = MD_MULT;
    md.rs_i = '0; md.rt_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("rst_busy", {63'b0, md.busy_o}, 64'd0);
    chk("rst_done", {63'b0, md.done_o}, 64'd0);
    chk("rst_hi", {32'b0, md.hi_o}, 64'd0);
    chk("rst_lo", {32'b0, md.lo_o}, 64'd0);

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5, -1, -1, -1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, -1, -1, -1);
    // back-to-back divisions, each started in the previous done cycle
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    run_op(MD_DIVU,  32'd100, 32'd7, -1, -1, -1);
    run_op(MD_DIVU,  32'd7, 32'd0, -1, -1, -1);
    @(posedge clk); #1;

    mt(MD_MTHI, 32'h1234_5678);
    mt(MD_MTLO, 32'hCAFE_F00D);

    // start during busy must be ignored
    run_op(MD_MULT, 32'd1234, 32'hFFFF_FF00, -1, -1, 5);

    // flush in IDLE blocks a same-cycle start
    md.op_i = MD_MULT; md.rs_i = 32'd9; md.rt_i = 32'd9;
    md.start_i = 1'b1; md.flush_i = 1'b1;
    @(posedge clk); #1;
    md.start_i = 1'b0; md.flush_i = 1'b0;
    chk("idle_flush_blocks_start", {63'b0, md.busy_o}, 64'd0);

    mt(MD_MTHI, 32'hA5A5_A5A5);
    mt(MD_MTLO, 32'hA5A5_A5A5);
    run_op(MD_MULT, 32'd3, 32'd4, 10, -1, -1);
    run_op(MD_MULT, 32'd3, 32'd4, -1, 20, -1);

    for (int i = 0; i < 24; i++) begin
      run_op(muldiv_op_t'($urandom_range(0, 3)), pick(), pick(), -1, -1, -1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
